// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Generic synchronous FIFO with first-word-fall-through read port.
// Latency: a push is visible on pop_vld the following cycle.
// Backpressure: push_rdy drops only when full and the head is not being popped.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             flush,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push;
    logic                  pop;

    // count never exceeds the depth, so its top bit alone means full
    assign pop_vld  = (count != '0);
    assign push_rdy = !count[ADDR_WIDTH] || pop_rdy;
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// Triggered snapshot capture of TPL ADC beats, drained as a valid/ready stream with last.
// Latency: a captured beat reaches dma_valid one cycle after it is presented (empty FIFO).
// Backpressure: dma_ready stalls the FIFO; a beat hitting a full FIFO sets overflow and ends capture.
module ad_ip_jesd204_tpl_adc_capture #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 1,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DATA_WIDTH      = NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CHANNELS-1:0]    adc_valid,
    input  logic [DATA_WIDTH-1:0]      adc_data,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 trigger_mode,
    input  logic                       trigger_ext,
    input  logic [BITS_PER_SAMPLE-1:0] trig_level,
    input  logic [COUNT_WIDTH-1:0]     capture_len,
    output logic                       dma_valid,
    input  logic                       dma_ready,
    output logic [DATA_WIDTH-1:0]      dma_data,
    output logic                       dma_last,
    output logic                       armed,
    output logic                       busy,
    output logic                       overflow,
    output logic                       done
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t                            state_q, state_d;
    logic [COUNT_WIDTH-1:0]            len_q, len_d;
    logic [COUNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic                              overflow_q, overflow_d;
    logic                              done_q, done_d;
    logic                              ext_q;
    logic                              ext_pend_q, ext_pend_d;
    logic signed [BITS_PER_SAMPLE-1:0] prev_s0_q, prev_s0_d;
    logic                              prev_ok_q, prev_ok_d;

    logic                              beat_vld;
    logic                              ext_rise;
    logic                              trig_hit;
    logic                              flush;
    logic                              wr_vld;
    logic                              wr_rdy;
    logic                              wr_last;
    logic signed [BITS_PER_SAMPLE-1:0] cur_s0;
    logic signed [BITS_PER_SAMPLE-1:0] level;

    assign beat_vld = &adc_valid;
    assign cur_s0   = $signed(adc_data[BITS_PER_SAMPLE-1:0]);
    assign level    = $signed(trig_level);
    assign ext_rise = trigger_ext && !ext_q;

    always_comb begin
        trig_hit = 1'b1;
        case (trigger_mode)
            2'd1:    trig_hit = ext_pend_q || ext_rise;
            2'd2:    trig_hit = prev_ok_q && (prev_s0_q <= level) && (cur_s0 > level);
            default: trig_hit = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        ext_pend_d = 1'b0;
        prev_s0_d  = prev_s0_q;
        prev_ok_d  = 1'b0;
        wr_vld     = 1'b0;
        wr_last    = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm && !abort && capture_len != '0) begin
                    state_d    = ARMED;
                    len_d      = capture_len;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            ARMED: begin
                ext_pend_d = ext_pend_q || ext_rise;
                prev_ok_d  = prev_ok_q;
                if (beat_vld) begin
                    prev_s0_d = cur_s0;
                    prev_ok_d = 1'b1;
                    // FIFO is always empty here, so the trigger beat can be written unconditionally
                    if (trig_hit) begin
                        wr_vld  = 1'b1;
                        wr_last = (len_q == COUNT_WIDTH'(1));
                        cnt_d   = COUNT_WIDTH'(1);
                        state_d = wr_last ? DRAIN : CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (beat_vld) begin
                    if (wr_rdy) begin
                        wr_vld  = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        wr_last = (cnt_d == len_q);
                        if (wr_last) state_d = DRAIN;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!dma_valid) begin
                    state_d = IDLE;
                    done_d  = !overflow_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            flush   = 1'b1;
            wr_vld  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            ext_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            prev_s0_q  <= '0;
            prev_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            ext_q      <= trigger_ext;
            ext_pend_q <= ext_pend_d;
            prev_s0_q  <= prev_s0_d;
            prev_ok_q  <= prev_ok_d;
        end
    end

    sync_fifo #(
        .WIDTH      (DATA_WIDTH + 1),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .core_clk (clk),
        .arst_n   (resetn),
        .flush    (flush),
        .push_vld (wr_vld),
        .push_rdy (wr_rdy),
        .push_dat ({wr_last, adc_data}),
        .pop_vld  (dma_valid),
        .pop_rdy  (dma_ready),
        .pop_dat  ({dma_last, dma_data})
    );

    assign armed    = (state_q == ARMED);
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign done     = done_q;
endmodule

// File: doc/ad_ip_jesd204_tpl_adc_capture.md
Name: ad_ip_jesd204_tpl_adc_capture

Overview:
Triggered snapshot capture stage that sits directly downstream of the JESD204 TPL ADC core. It consumes the core's formatted per-beat channel data and valid flags. After an arm request it waits for a trigger, captures a programmed number of beats into an internal FIFO, and drains them to a DMA-style valid/ready stream with a last marker.

Parameters:
NUM_CHANNELS, 4, number of converter channels in adc_data
DATA_PATH_WIDTH, 1, samples per channel per beat
BITS_PER_SAMPLE, 16, formatted sample width
DATA_WIDTH, NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE, beat width
FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH entries
COUNT_WIDTH, 16, width of capture length counter

Ports:
clk  in  1  core clock; single clock domain
resetn  in  1  asynchronous active-low reset
adc_valid  in  NUM_CHANNELS  per-channel valid; a beat is valid when all bits are 1
adc_data  in  DATA_WIDTH  formatted beat; channel 0 sample 0 = bits [BITS_PER_SAMPLE-1:0]
arm  in  1  pulse; starts a capture sequence from IDLE
abort  in  1  pulse; cancels capture, empties FIFO
trigger_mode  in  2  0 immediate, 1 external rising edge, 2 level crossing, 3 reserved (treated as 0)
trigger_ext  in  1  external trigger, synchronous to clk
trig_level  in  BITS_PER_SAMPLE  signed threshold for mode 2
capture_len  in  COUNT_WIDTH  beats to capture; sampled on arm
dma_valid  out  1  output beat valid
dma_ready  in  1  consumer ready
dma_data  out  DATA_WIDTH  output beat
dma_last  out  1  marks final captured beat
armed  out  1  high in ARMED
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky; cleared on the next accepted arm
done  out  1  one-cycle pulse on return to IDLE after a normal completion

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, FIFO empty, counter 0, trigger history cleared.
  - All outputs 0.
  - Reset mid-capture discards all data.
- States:
  - IDLE:
    - arm with capture_len!=0 -> ARMED; latch capture_len, clear overflow.
    - arm with capture_len==0 is ignored.
  - ARMED: evaluated on valid beats only.
    - Mode 0: the first valid beat triggers.
    - Mode 1: a rising edge of trigger_ext (registered previous value 0, current 1) sets a pending flag. The first valid beat in the same or a later cycle triggers.
    - Mode 2: triggers when prev_s0 <= trig_level and cur_s0 > trig_level, both signed. prev_s0 is channel 0 sample 0 of the previous valid beat. prev_s0 is invalid for the first beat after arm, so no trigger on that beat.
    - The trigger beat is the first captured beat. Go to CAPTURE and write that beat.
  - CAPTURE: each valid beat is written and the counter increments.
    - When the counter reaches the latched length, the write carries last=1 -> DRAIN.
    - capture_len==1: the trigger beat carries last=1 and goes directly ARMED -> DRAIN.
  - DRAIN: ignores adc input. When the FIFO is empty and the output register is empty -> IDLE and pulse done.
- arm outside IDLE is ignored.
- abort in ARMED, CAPTURE or DRAIN:
  - next cycle IDLE, FIFO flushed, dma_valid low, no done pulse.
  - abort beats arm when both are asserted in the same cycle.
- FIFO:
  - Entries are {last, data}. Write on a valid beat while capturing.
  - First-word-fall-through output register; dma_valid asserts 1 cycle after the first write.
  - Pop when dma_valid && dma_ready. Simultaneous push and pop at full is legal (occupancy unchanged).
  - Full-cycle throughput: one beat per clock in and out.
  - dma_data and dma_last are held stable while dma_valid && !dma_ready.
- Overflow:
  - A valid beat arriving while the FIFO is full and not popping sets overflow and drops the beat.
  - State -> DRAIN (capture aborted). Already-stored beats drain; no dma_last is emitted.
- Wrap-around: a capture_len of all ones is supported (the counter compares, never wraps).

Test Plan:
- Mode 0, capture_len=5, dma_ready=1, valid every cycle -> 5 beats out, equal to input beats 0..4, dma_last on the 5th, done pulse once, first dma_valid 2 cycles after arm+first beat.
- Mode 2, trig_level=100, ch0 samples 50,90,120,130 -> capture starts at the beat with 120, not the one with 130; a first beat of 120 after arm does not trigger.
- Mode 1, trigger_ext rises while adc_valid=0 for 3 cycles -> the first valid beat afterwards is captured first; a second edge during CAPTURE has no effect.
- FIFO depth 16, capture_len=40, dma_ready=0 -> 16 beats stored, overflow=1, DRAIN; releasing ready gives 16 beats with no dma_last, then busy=0, done=0; the next arm clears overflow.
- Backpressure toggling ready every other cycle with capture_len=8 -> no data loss, dma_data stable while stalled.
- abort mid-CAPTURE and resetn low mid-DRAIN -> IDLE next cycle, dma_valid=0, FIFO empty, all outputs 0.
